// File: rtl/axi_arbiter_2x1.sv
// axi_arbiter_2x1: two-master (IFU read-only, LSU read/write) single-beat AXI-lite arbiter onto one slave port.
// Define ARB_RR_EN to make read ties round-robin instead of fixed priority by LSU_PRIO.
module axi_arbiter_2x1 #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m0_AR_ADDR,
  input  logic                m0_AR_VALID,
  output logic                m0_AR_READY,
  output logic [DATA_W-1:0]   m0_R_DATA,
  output logic                m0_R_VALID,
  input  logic                m0_R_READY,
  input  logic [ADDR_W-1:0]   m1_AR_ADDR,
  input  logic                m1_AR_VALID,
  output logic                m1_AR_READY,
  output logic [DATA_W-1:0]   m1_R_DATA,
  output logic                m1_R_VALID,
  input  logic                m1_R_READY,
  input  logic [ADDR_W-1:0]   m1_AW_ADDR,
  input  logic                m1_AW_VALID,
  output logic                m1_AW_READY,
  input  logic [DATA_W-1:0]   m1_W_DATA,
  input  logic [DATA_W/8-1:0] m1_W_STRB,
  input  logic                m1_W_VALID,
  output logic                m1_W_READY,
  output logic                m1_B_VALID,
  input  logic                m1_B_READY,
  output logic [ADDR_W-1:0]   s_AR_ADDR,
  output logic                s_AR_VALID,
  input  logic                s_AR_READY,
  input  logic [DATA_W-1:0]   s_R_DATA,
  input  logic                s_R_VALID,
  output logic                s_R_READY,
  output logic [ADDR_W-1:0]   s_AW_ADDR,
  output logic                s_AW_VALID,
  input  logic                s_AW_READY,
  output logic [DATA_W-1:0]   s_W_DATA,
  output logic [DATA_W/8-1:0] s_W_STRB,
  output logic                s_W_VALID,
  input  logic                s_W_READY,
  input  logic                s_B_VALID,
  output logic                s_B_READY
);
  localparam logic [1:0] IDLE = 2'd0, RD0 = 2'd1, RD1 = 2'd2, WR = 2'd3;
  logic [1:0] state, state_nxt;
  logic rd0, rd1, wr, ar_done, aw_done, w_done, wr_req, both_rd, tie_m1, b_open;
  assign rd0 = state == RD0;
  assign rd1 = state == RD1;
  assign wr = state == WR;
  assign wr_req = m1_AW_VALID | m1_W_VALID;
  assign both_rd = m0_AR_VALID & m1_AR_VALID;
`ifdef ARB_RR_EN
  logic rr_last;
  assign tie_m1 = ~rr_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last <= 1'b0;
    else if (state == IDLE && !wr_req && both_rd) rr_last <= tie_m1;
`else
  assign tie_m1 = LSU_PRIO;
`endif
  // Grant is purely registered: slave-side VALIDs only appear once the FSM leaves IDLE.
  assign state_nxt = state == IDLE
    ? (wr_req ? WR : both_rd ? (tie_m1 ? RD1 : RD0) : m1_AR_VALID ? RD1 : m0_AR_VALID ? RD0 : IDLE)
    : ((wr ? s_B_VALID & s_B_READY : s_R_VALID & s_R_READY) ? IDLE : state);
  assign s_AR_ADDR = rd0 ? m0_AR_ADDR : rd1 ? m1_AR_ADDR : '0;
  assign s_AR_VALID = ~ar_done & (rd0 ? m0_AR_VALID : rd1 & m1_AR_VALID);
  assign m0_AR_READY = rd0 & ~ar_done & s_AR_READY;
  assign m1_AR_READY = rd1 & ~ar_done & s_AR_READY;
  assign s_R_READY = rd0 ? m0_R_READY : rd1 & m1_R_READY;
  assign m0_R_VALID = rd0 & s_R_VALID;
  assign m1_R_VALID = rd1 & s_R_VALID;
  assign m0_R_DATA = rst_n ? s_R_DATA : '0;
  assign m1_R_DATA = rst_n ? s_R_DATA : '0;
  assign s_AW_ADDR = wr ? m1_AW_ADDR : '0;
  assign s_AW_VALID = wr & ~aw_done & m1_AW_VALID;
  assign m1_AW_READY = wr & ~aw_done & s_AW_READY;
  assign s_W_DATA = wr ? m1_W_DATA : '0;
  assign s_W_STRB = wr ? m1_W_STRB : '0;
  assign s_W_VALID = wr & ~w_done & m1_W_VALID;
  assign m1_W_READY = wr & ~w_done & s_W_READY;
  assign b_open = wr & aw_done & w_done;
  assign s_B_READY = b_open & m1_B_READY;
  assign m1_B_VALID = b_open & s_B_VALID;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      state <= state_nxt;
      ar_done <= (state_nxt != IDLE) & (ar_done | (s_AR_VALID & s_AR_READY));
      aw_done <= (state_nxt != IDLE) & (aw_done | (s_AW_VALID & s_AW_READY));
      w_done <= (state_nxt != IDLE) & (w_done | (s_W_VALID & s_W_READY));
    end
endmodule
